// File: rtl/tdm_demux1to8_pkg.sv
// tdm_pkg: shared slot-count, state and parity-slot constants for the TDM link (TDM_DEMUX_PARITY_EN adds a parity slot)
package tdm_pkg;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NUM_SLOTS = 9;
  localparam int SLOT_W = 4;
`else
  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W = 3;
`endif
  localparam int NUM_LANES = 8;
  localparam int PAR_SLOT = 8;
  typedef enum logic {HUNT, RUN} tdm_state_t;
endpackage

// File: rtl/tdm_demux1to8_slot_ctr.sv
// tdm_slot_ctr: modulo-NUM_SLOTS slot index with clear, load-1 and advance (clear wins, then load-1)
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic              i_load1,
  input  logic              i_clr,
  output logic [SLOT_W-1:0] o_sel
);
  logic [SLOT_W-1:0] r_sel;
  logic [SLOT_W-1:0] w_sel_nx;
  always_comb
    w_sel_nx = i_clr ? '0 :
               i_load1 ? SLOT_W'(1) :
               !i_adv ? r_sel :
               (r_sel == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_sel + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sel <= '0;
    else r_sel <= w_sel_nx;
  assign o_sel = r_sel;
endmodule

// File: rtl/tdm_demux1to8.sv
// tdm_demux1to8: 8-lane TDM receiver locking to frame sync (TDM_DEMUX_PARITY_EN adds a checked parity slot and par_err)
module tdm_demux1to8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  input  logic                         in_sync,
  output logic [NUM_LANES*WIDTH-1:0]   out_data,
  output logic                         out_valid,
  output logic [SLOT_W-1:0]            sel,
`ifdef TDM_DEMUX_PARITY_EN
  output logic                         par_err,
`endif
  output logic                         locked,
  output logic                         sync_err
);
  tdm_state_t r_state, w_state_nx;
  logic [NUM_LANES*WIDTH-1:0] r_cap, w_cap_nx, r_out;
  logic [SLOT_W-1:0] w_sel, w_lane;
  logic w_run, w_sel0, w_last, w_sync, w_adv, w_clr, w_err, w_done, w_fire;
  logic r_valid, r_serr;
  tdm_slot_ctr u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_adv   (w_adv),
    .i_load1 (w_sync),
    .i_clr   (w_clr),
    .o_sel   (w_sel)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= HUNT;
    else r_state <= w_state_nx;
  always_comb
    w_state_nx = (r_state == HUNT) ? (w_sync ? RUN : HUNT) :
                 (in_valid && w_sel0 && !in_sync) ? HUNT : RUN;
  always_comb begin
    w_run  = r_state == RUN;
    w_sel0 = w_sel == '0;
    w_last = w_sel == SLOT_W'(NUM_SLOTS - 1);
    w_sync = in_valid && in_sync;
    w_adv  = w_run && in_valid && !in_sync && !w_sel0;
    w_clr  = w_run && in_valid && !in_sync && w_sel0;
    w_err  = w_run && in_valid && (in_sync ? !w_sel0 : w_sel0);
    w_done = w_adv && w_last;
    w_lane = in_sync ? '0 : w_sel;
  end
  // a sync beat always restarts the frame at lane 0, discarding any partial frame
  always_comb begin
    w_cap_nx = r_cap;
    for (int k = 0; k < NUM_LANES; k++)
      if ((w_sync || w_adv) && w_lane == SLOT_W'(k)) w_cap_nx[k*WIDTH +: WIDTH] = in_data;
  end
`ifdef TDM_DEMUX_PARITY_EN
  logic [WIDTH-1:0] w_par;
  logic r_perr;
  always_comb begin
    w_par = '0;
    for (int k = 0; k < NUM_LANES; k++) w_par = w_par ^ r_cap[k*WIDTH +: WIDTH];
  end
  assign w_fire = w_done && (in_data == w_par);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_perr <= 1'b0;
    else r_perr <= w_done && (in_data != w_par);
  assign par_err = r_perr;
`else
  assign w_fire = w_done;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cap   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_cap   <= w_cap_nx;
      r_out   <= w_fire ? w_cap_nx : r_out;
      r_valid <= w_fire;
      r_serr  <= w_err;
    end
  assign out_data  = r_out;
  assign out_valid = r_valid;
  assign sel       = w_sel;
  assign locked    = w_run;
  assign sync_err  = r_serr;
endmodule
